pcs_rx_link_ctrl: RTL
=====================

# pcs_rx_link_ctrl

Receive-side link controller for the 10GBASE-R PCS, in the `xver_rx_clk` domain.
- Sequences PCS RX bring-up: holds the PCS RX path in reset, qualifies block lock from the sync-header stream, and runs a clause-49-style high-BER monitor over fixed windows.
- Re-issues the RX reset when lock or BER recovery fails.
- Drives the PCS `rx_reset` input and reports link status to the MAC and management logic.

## Interface
- `RESET_CYCLES`, default 16: cycles `o_rx_pcs_reset` is held high per reset pulse.
- `LOCK_GOOD`, default 64: consecutive valid sync headers required to declare lock.
- `LOCK_TIMEOUT`, default 65536: cycles allowed in WAIT_LOCK before re-reset.
- `BER_WINDOW`, default 40283: BER window length in cycles (125 µs at 322.27 MHz).
- `BER_THRESH`, default 16: invalid headers per window that set hi-BER.
- `HIBER_LIMIT`, default 8: consecutive failing windows in HI_BER before re-reset.
- `i_clk` input 1: receive clock (`xver_rx_clk`).
- `i_reset` input 1: synchronous, active-high reset.
- `i_header` input 2: sync header from the RX gearbox/transceiver.
- `i_header_valid` input 1: `i_header` qualifier.
- `i_slip` input 1: slip pulse from `lock_state`.
- `o_rx_pcs_reset` output 1: reset to the PCS RX datapath.
- `o_link_up` output 1: block lock held and BER acceptable.
- `o_hi_ber` output 1: high-BER condition.
- `o_ber_count` output 6: invalid headers in the current window, saturating at 63.
- `o_relock_count` output 8: number of controller-initiated re-resets, saturating at 255.

## Operation
- A header is valid if it equals `SYNC_DATA` (2'b01) or `SYNC_CTRL` (2'b10). It is invalid otherwise. Headers are only evaluated when `i_header_valid`=1.
- States: RESET, WAIT_LOCK, LINK_UP, HI_BER.
- **RESET:** `o_rx_pcs_reset`=1 and the timer counts. After `RESET_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - good_cnt increments on each valid header.
  - An invalid header or `i_slip` clears good_cnt.
  - When good_cnt reaches `LOCK_GOOD`, go to LINK_UP.
  - When the timer reaches `LOCK_TIMEOUT`, go to RESET and increment relock.
  - Lock takes priority over timeout on the same cycle.
- **LINK_UP:**
  - The window timer runs. Each invalid header increments err_cnt.
  - When err_cnt reaches `BER_THRESH`, go to HI_BER immediately.
  - On `i_slip`, go to WAIT_LOCK. Slip has priority over hi-BER.
  - At the end of a window, err_cnt and the timer clear.
- **HI_BER:**
  - Windows continue.
  - A window that ends with err_cnt < `BER_THRESH` returns to LINK_UP.
  - After `HIBER_LIMIT` consecutive failing windows, go to RESET and increment relock.
  - `i_slip` goes to WAIT_LOCK.
- On every state entry, the timer, good_cnt, err_cnt and fail-window counter clear.
- An invalid header on the last cycle of a window counts toward that window.

## Timing
- On `i_reset` (taking effect at any point, including mid-window): state=RESET, all counters 0.
  - `o_rx_pcs_reset`=1.
  - `o_link_up`, `o_hi_ber`, `o_ber_count` and `o_relock_count` are 0.
  - `o_relock_count` is not cleared by controller-initiated RESET, only by `i_reset`.
- Outputs are decoded from the registered state and counters. A transition condition at cycle N is visible on the outputs at N+1.
- First lock after `i_reset` deasserts: earliest `o_link_up` is `RESET_CYCLES` + `LOCK_GOOD` + 1 cycles.
- `o_ber_count` is the live err_cnt. It returns to 0 on the cycle after a window ends.
- Counter widths are `$clog2(param+1)`. No counter wraps; saturating counters hold at max.

## Structure
- `code_defs_pkg` holds:
  - `SYNC_DATA` and `SYNC_CTRL` constants.
  - `pcs_link_state_t` enum (RESET, WAIT_LOCK, LINK_UP, HI_BER).
- Sub-module `ber_window_mon`: window timer plus saturating err_cnt.
  - Inputs: clear, invalid strobe.
  - Outputs: window_end, thresh_hit, count.
- The parent holds the FSM, lock qualification and relock counter.
- Instantiated in the PCS top, replacing direct drive of `rx_reset`.

## Test plan
Parameters for the bench: RESET_CYCLES=4, LOCK_GOOD=8, LOCK_TIMEOUT=200, BER_WINDOW=100, BER_THRESH=4, HIBER_LIMIT=2.
- **Clean bring-up:** release `i_reset`, then drive valid headers every cycle → `o_rx_pcs_reset` low after 4 cycles; `o_link_up`=1 at cycle 13.
- **Lock interrupted:** 7 valid headers, then 1 invalid, then 8 valid → lock declared only after the second run of 8.
- **Lock timeout:** drive only 2'b00 headers → RESET re-entered at 200 cycles in WAIT_LOCK; `o_relock_count`=1; `o_rx_pcs_reset` high for 4 cycles.
- **High BER and recovery:** in LINK_UP, 4 invalid headers within one window → `o_hi_ber`=1 and `o_link_up`=0 next cycle; then a clean window → LINK_UP.
- **Persistent BER:** 4 or more invalid headers in each of 2 windows in HI_BER → RESET; `o_relock_count` increments.
- **Simultaneous events:** `i_slip` with the 4th invalid header in LINK_UP → WAIT_LOCK, `o_hi_ber` stays 0. Also assert `i_reset` mid-window → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/code_defs_pkg.sv
// Shared 10GBASE-R receive definitions: sync-header codes, link FSM states and
// status field widths.
package code_defs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int BER_COUNT_W = 6;
    localparam int RELOCK_W    = 8;

    typedef enum logic [1:0] {
        RESET,
        WAIT_LOCK,
        LINK_UP,
        HI_BER
    } pcs_link_state_t;

    // 2'b00 and 2'b11 are the only illegal sync headers.
    function automatic logic header_ok(input logic [1:0] header);
        return (header == SYNC_DATA) || (header == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_link_ctrl_if.sv
// Header stream from the RX gearbox plus link status back to the MAC and
// management side.
interface pcs_rx_link_ctrl_if;
    import code_defs_pkg::*;

    logic [1:0]             i_header;
    logic                   i_header_valid;
    logic                   i_slip;
    logic                   o_rx_pcs_reset;
    logic                   o_link_up;
    logic                   o_hi_ber;
    logic [BER_COUNT_W-1:0] o_ber_count;
    logic [RELOCK_W-1:0]    o_relock_count;

    modport master (
        output i_header, i_header_valid, i_slip,
        input  o_rx_pcs_reset, o_link_up, o_hi_ber, o_ber_count, o_relock_count
    );

    modport slave (
        input  i_header, i_header_valid, i_slip,
        output o_rx_pcs_reset, o_link_up, o_hi_ber, o_ber_count, o_relock_count
    );

endinterface

// File: rtl/ber_window_mon.sv
// Fixed-length BER window: free-running window timer plus a saturating count
// of invalid sync headers seen inside the current window.
module ber_window_mon
    import code_defs_pkg::*;
#(
    parameter int BER_WINDOW = 40283,
    parameter int BER_THRESH = 16
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   invalid,
    output logic                   window_end,
    output logic                   thresh_hit,
    output logic [BER_COUNT_W-1:0] count
);

    localparam int                     WIN_W    = $clog2(BER_WINDOW + 1);
    localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(BER_WINDOW - 1);
    localparam logic [BER_COUNT_W-1:0] CNT_MAX  = '1;

    logic [WIN_W-1:0]       timer;
    logic [BER_COUNT_W-1:0] count_next;

    // The strobe on the final window cycle is folded in before the verdict.
    assign count_next = (invalid && count != CNT_MAX) ? count + 1'b1 : count;
    assign window_end = (timer == WIN_LAST);
    assign thresh_hit = int'(count_next) >= BER_THRESH;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (clear || window_end) begin
            timer <= '0;
            count <= '0;
        end else begin
            timer <= timer + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// PCS receive link controller: sequences RX reset, qualifies block lock and
// supervises BER, re-resetting the RX path when recovery stalls.
module pcs_rx_link_ctrl
    import code_defs_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_GOOD    = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int BER_WINDOW   = 40283,
    parameter int BER_THRESH   = 16,
    parameter int HIBER_LIMIT  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    pcs_rx_link_ctrl_if.slave  link
);

    localparam int TMR_MAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_GOOD + 1);
    localparam int FAIL_W  = $clog2(HIBER_LIMIT + 1);

    localparam logic [TMR_W-1:0]    TMR_SAT     = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0]    RST_LAST    = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0]    TIMEOUT     = TMR_W'(LOCK_TIMEOUT);
    localparam logic [GOOD_W-1:0]   GOOD_TARGET = GOOD_W'(LOCK_GOOD);
    localparam logic [FAIL_W-1:0]   FAIL_LAST   = FAIL_W'(HIBER_LIMIT - 1);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX  = '1;

    pcs_link_state_t        state;
    pcs_link_state_t        state_next;
    logic                   relock_evt;
    logic [TMR_W-1:0]       timer;
    logic [GOOD_W-1:0]      good_cnt;
    logic [FAIL_W-1:0]      fail_cnt;
    logic [RELOCK_W-1:0]    relock_cnt;
    logic                   rx_pcs_reset;
    logic                   link_up;
    logic                   hi_ber;
    logic                   hdr_good;
    logic                   hdr_bad;
    logic                   win_clear;
    logic                   window_end;
    logic                   thresh_hit;
    logic [BER_COUNT_W-1:0] ber_count;

    assign hdr_good = link.i_header_valid &&  header_ok(link.i_header);
    assign hdr_bad  = link.i_header_valid && !header_ok(link.i_header);

    // The window only runs in LINK_UP/HI_BER and restarts on every state entry.
    assign win_clear = i_reset || (state_next != state) ||
                       (state == RESET) || (state == WAIT_LOCK);

    ber_window_mon #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber_mon (
        .clk        (i_clk),
        .clear      (win_clear),
        .invalid    (hdr_bad),
        .window_end (window_end),
        .thresh_hit (thresh_hit),
        .count      (ber_count)
    );

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        relock_evt = 1'b0;
        case (state)
            RESET: begin
                if (timer == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (good_cnt == GOOD_TARGET) begin
                    state_next = LINK_UP;
                end else if (timer == TIMEOUT) begin
                    state_next = RESET;
                    relock_evt = 1'b1;
                end
            end
            LINK_UP: begin
                if (link.i_slip)     state_next = WAIT_LOCK;
                else if (thresh_hit) state_next = HI_BER;
            end
            HI_BER: begin
                if (link.i_slip) begin
                    state_next = WAIT_LOCK;
                end else if (window_end) begin
                    if (!thresh_hit) begin
                        state_next = LINK_UP;
                    end else if (fail_cnt == FAIL_LAST) begin
                        state_next = RESET;
                        relock_evt = 1'b1;
                    end
                end
            end
            default: state_next = RESET;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= RESET;
            timer        <= '0;
            good_cnt     <= '0;
            fail_cnt     <= '0;
            relock_cnt   <= '0;
            rx_pcs_reset <= 1'b1;
            link_up      <= 1'b0;
            hi_ber       <= 1'b0;
        end else begin
            state        <= state_next;
            rx_pcs_reset <= (state_next == RESET);
            link_up      <= (state_next == LINK_UP);
            hi_ber       <= (state_next == HI_BER);

            if (relock_evt && relock_cnt != RELOCK_MAX) relock_cnt <= relock_cnt + 1'b1;

            if (state_next != state) begin
                timer    <= '0;
                good_cnt <= '0;
                fail_cnt <= '0;
            end else begin
                if (timer != TMR_SAT) timer <= timer + 1'b1;

                if (state == WAIT_LOCK) begin
                    if (link.i_slip || hdr_bad)
                        good_cnt <= '0;
                    else if (hdr_good && good_cnt != GOOD_TARGET)
                        good_cnt <= good_cnt + 1'b1;
                end

                // The last allowed failure leaves HI_BER, so this never exceeds the limit.
                if (state == HI_BER && window_end && thresh_hit) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign link.o_rx_pcs_reset = rx_pcs_reset;
    assign link.o_link_up      = link_up;
    assign link.o_hi_ber       = hi_ber;
    assign link.o_ber_count    = ber_count;
    assign link.o_relock_count = relock_cnt;

endmodule
